alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_arb_pkg.sv | 31 +++
 rtl/alu_unit.sv | 35 +++
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared definitions for the ALU share arbiter: ALU operation
//                encodings, grant-statistics counter width and a saturating
//                increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

    // ALU operation select encodings
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    // Width of each per-requester grant counter
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_unit.sv
// ============================================================================
//  Module      : ALU_Unit
//  Description : Purely combinational ALU shared by both requesters.
//  Ports       : a_i, b_i  - operands (BITS)
//                sel_i     - operation (add/sub/and/or)
//                y_o       - result (BITS), sub wraps modulo 2^BITS
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ALU_Unit
    import alu_arb_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    input  logic [1:0]      sel_i,
    output logic [BITS-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (alu_op_e'(sel_i))
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Two requesters share one ALU. A round-robin pointer picks a
//                requester under contention; the result is registered in a
//                single output slot with valid/ready handshake and full
//                throughput (drain and refill on the same edge).
//  Ports       : clk, rst_n (sync, active-low)
//                reqN_valid/ready, reqN_a/b/sel  - requester N operation
//                res_valid/ready, res_data/zero/id - result slot
//                grant_cnt0/1 - saturating accept counters
//  Config      : define ALU_ARB_STATS_EN to build the grant counters;
//                otherwise they read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [BITS-1:0]  req0_a,
    input  logic [BITS-1:0]  req0_b,
    input  logic [BITS-1:0]  req1_a,
    input  logic [BITS-1:0]  req1_b,
    input  logic [1:0]       req0_sel,
    input  logic [1:0]       req1_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [BITS-1:0]  res_data,
    output logic             res_zero,
    output logic             res_id,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    logic            res_valid_q, res_valid_d;
    logic [BITS-1:0] res_data_q,  res_data_d;
    logic            res_zero_q,  res_zero_d;
    logic            res_id_q,    res_id_d;
    logic            ptr_q,       ptr_d;

    logic            slot_free;
    logic            gnt0, gnt1;
    logic            acc0, acc1, acc;
    logic [BITS-1:0] op_a, op_b, alu_y;
    logic [1:0]      op_sel;

    // Arbitration: a lone requester always wins; under contention the
    // pointer picks. Ready is forced low while reset is asserted.
    always_comb begin
        slot_free  = !res_valid_q || res_ready;
        gnt0       = req0_valid && (!req1_valid || !ptr_q);
        gnt1       = req1_valid && (!req0_valid ||  ptr_q);
        req0_ready = rst_n && slot_free && gnt0;
        req1_ready = rst_n && slot_free && gnt1;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        acc        = acc0 || acc1;
        op_a       = gnt1 ? req1_a   : req0_a;
        op_b       = gnt1 ? req1_b   : req0_b;
        op_sel     = gnt1 ? req1_sel : req0_sel;
    end

    ALU_Unit #(
        .BITS (BITS)
    ) u_alu (
        .a_i   (op_a),
        .b_i   (op_b),
        .sel_i (op_sel),
        .y_o   (alu_y)
    );

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_id_d    = res_id_q;
        ptr_d       = ptr_q;
        if (acc) begin
            // New accept overwrites the slot even if it is draining now
            res_valid_d = 1'b1;
            res_data_d  = alu_y;
            res_zero_d  = (alu_y == '0);
            res_id_d    = acc1;
            ptr_d       = !acc1;
        end else if (res_ready) begin
            // Drain only; payload is kept, just marked empty
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_id_q    <= 1'b0;
            ptr_q       <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_id_q    <= res_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_id    = res_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (acc0) cnt0_q <= sat_inc(cnt0_q);
            if (acc1) cnt1_q <= sat_inc(cnt1_q);
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Directed, table-driven bench for alu_share_arbiter (BITS=64)
//                with hand-written reset and statistics sequences.
//  Config      : honours ALU_ARB_STATS_EN for the grant-counter checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

    localparam int BITS = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [BITS-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]      req0_sel, req1_sel;
    logic            res_valid, res_ready;
    logic [BITS-1:0] res_data;
    logic            res_zero, res_id;
    logic [15:0]     grant_cnt0, grant_cnt1;

    alu_share_arbiter #(.BITS(BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_sel   (req0_sel),
        .req1_sel   (req1_sel),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_id     (res_id),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [63:0] a0, b0;
        logic [1:0]  s0;
        logic        v1;
        logic [63:0] a1, b1;
        logic [1:0]  s1;
        logic        rr;
        logic        e_r0, e_r1, e_v;
        logic [63:0] e_d;
        logic        e_z, e_id;
    } vec_t;

    vec_t tbl [15];

    int n_checks = 0;
    int n_fail   = 0;

    // Previous-cycle handshake state for the operand-stability check
    logic        h0 = 1'b0, h1 = 1'b0;
    logic [63:0] pa0, pb0, pa1, pb1;
    logic [1:0]  ps0, ps1;

    function automatic vec_t mk(
        input logic v0, input logic [63:0] a0, b0, input logic [1:0] s0,
        input logic v1, input logic [63:0] a1, b1, input logic [1:0] s1,
        input logic rr, input logic r0, r1, v,
        input logic [63:0] d, input logic z, id);
        vec_t t;
        t.v0 = v0; t.a0 = a0; t.b0 = b0; t.s0 = s0;
        t.v1 = v1; t.a1 = a1; t.b1 = b1; t.s1 = s1;
        t.rr = rr; t.e_r0 = r0; t.e_r1 = r1; t.e_v = v;
        t.e_d = d; t.e_z = z; t.e_id = id;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        req0_valid = t.v0; req0_a = t.a0; req0_b = t.b0; req0_sel = t.s0;
        req1_valid = t.v1; req1_a = t.a1; req1_b = t.b1; req1_sel = t.s1;
        res_ready  = t.rr;
    endtask

    // A requester left waiting last cycle must present the same operation now
    task automatic stab();
        if (h0 && req0_valid) begin
            n_checks++;
            if (req0_a !== pa0 || req0_b !== pb0 || req0_sel !== ps0) begin
                n_fail++;
                $display("FAIL req0_hold: operands changed while waiting at %0t", $time);
            end
        end
        if (h1 && req1_valid) begin
            n_checks++;
            if (req1_a !== pa1 || req1_b !== pb1 || req1_sel !== ps1) begin
                n_fail++;
                $display("FAIL req1_hold: operands changed while waiting at %0t", $time);
            end
        end
        h0 = rst_n && req0_valid && !req0_ready;
        h1 = rst_n && req1_valid && !req1_ready;
        pa0 = req0_a; pb0 = req0_b; ps0 = req0_sel;
        pa1 = req1_a; pb1 = req1_b; ps1 = req1_sel;
    endtask

    task automatic to_neg();
        @(negedge clk);
        stab();
    endtask

    task automatic to_post();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string nm, input logic v, input logic [63:0] d,
                           input logic z, input logic id);
        chk({nm, ".res_valid"}, {63'd0, res_valid}, {63'd0, v});
        chk({nm, ".res_data"},  res_data, d);
        chk({nm, ".res_zero"},  {63'd0, res_zero}, {63'd0, z});
        chk({nm, ".res_id"},    {63'd0, res_id},   {63'd0, id});
    endtask

    task automatic chk_rdy(input string nm, input logic r0, input logic r1);
        chk({nm, ".req0_ready"}, {63'd0, req0_ready}, {63'd0, r0});
        chk({nm, ".req1_ready"}, {63'd0, req1_ready}, {63'd0, r1});
    endtask

    initial begin
        // Operation table; pointer/slot state carries from row to row
        tbl[0]  = mk(1, 5, 7, 2'b00,          0, 0, 0, 2'b00,     1, 1, 0, 1, 12, 0, 0);
        tbl[1]  = mk(0, 0, 0, 2'b00,          0, 0, 0, 2'b00,     1, 0, 0, 0, 12, 0, 0);
        tbl[2]  = mk(1, 9, 9, 2'b01,          1, 1, 2, 2'b11,     1, 0, 1, 1, 3, 0, 1);
        tbl[3]  = mk(1, 9, 9, 2'b01,          1, 1, 2, 2'b11,     1, 1, 0, 1, 0, 1, 0);
        tbl[4]  = mk(1, 9, 9, 2'b01,          1, 1, 2, 2'b11,     1, 0, 1, 1, 3, 0, 1);
        tbl[5]  = mk(0, 0, 0, 2'b00,          1, 0, 1, 2'b01,     0, 0, 0, 1, 3, 0, 1);
        tbl[6]  = mk(0, 0, 0, 2'b00,          1, 0, 1, 2'b01,     0, 0, 0, 1, 3, 0, 1);
        tbl[7]  = mk(0, 0, 0, 2'b00,          1, 0, 1, 2'b01,     0, 0, 0, 1, 3, 0, 1);
        tbl[8]  = mk(0, 0, 0, 2'b00,          1, 0, 1, 2'b01,     1, 0, 1, 1, ONES, 0, 1);
        tbl[9]  = mk(1, 64'hF0, 64'h0F, 2'b10, 0, 0, 0, 2'b00,    0, 0, 0, 1, ONES, 0, 1);
        tbl[10] = mk(1, 64'hF0, 64'h0F, 2'b10, 0, 0, 0, 2'b00,    1, 1, 0, 1, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 2'b00,          0, 0, 0, 2'b00,     0, 0, 0, 1, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 2'b00,          0, 0, 0, 2'b00,     1, 0, 0, 0, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 2'b00,          1, ONES, 1, 2'b00,  1, 0, 1, 1, 0, 1, 1);
        tbl[14] = mk(1, 0, 64'h8000_0000_0000_0000, 2'b11, 0, 0, 0, 2'b00,
                     1, 1, 0, 1, 64'h8000_0000_0000_0000, 0, 0);

        // Reset with both requesters asking: nothing may be accepted
        rst_n = 1'b0;
        drive(mk(1, 5, 7, 2'b00, 1, 1, 2, 2'b11, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            to_neg();
            chk_rdy("reset", 1'b0, 1'b0);
            to_post();
        end
        chk_res("reset", 1'b0, 64'd0, 1'b0, 1'b0);
        chk("reset.grant_cnt0", {48'd0, grant_cnt0}, 64'd0);
        chk("reset.grant_cnt1", {48'd0, grant_cnt1}, 64'd0);

        rst_n = 1'b1;
        drive(mk(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0));
        to_post();

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i]);
            to_neg();
            chk_rdy($sformatf("vec%0d", i), tbl[i].e_r0, tbl[i].e_r1);
            to_post();
            chk_res($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_d, tbl[i].e_z, tbl[i].e_id);
        end

        // Reset for one cycle while a result sits in the slot (pointer is 1)
        rst_n = 1'b0;
        drive(mk(1, 5, 7, 2'b00, 1, 1, 2, 2'b11, 0, 0, 0, 0, 0, 0, 0));
        to_neg();
        chk_rdy("midrst", 1'b0, 1'b0);
        to_post();
        chk_res("midrst", 1'b0, 64'd0, 1'b0, 1'b0);

        // Contention right after reset must favour requester 0, then 1
        rst_n = 1'b1;
        res_ready = 1'b1;
        to_neg();
        chk_rdy("postrst0", 1'b1, 1'b0);
        to_post();
        chk_res("postrst0", 1'b1, 64'd12, 1'b0, 1'b0);
        to_neg();
        chk_rdy("postrst1", 1'b0, 1'b1);
        to_post();
        chk_res("postrst1", 1'b1, 64'd3, 1'b0, 1'b1);

`ifdef ALU_ARB_STATS_EN
        chk("stats.cnt0_start", {48'd0, grant_cnt0}, 64'd1);
        chk("stats.cnt1_start", {48'd0, grant_cnt1}, 64'd1);
        drive(mk(1, 5, 7, 2'b00, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 70000; i++) begin
            to_neg();
            to_post();
        end
        chk("stats.cnt0_sat", {48'd0, grant_cnt0}, 64'hFFFF);
        chk("stats.cnt1_held", {48'd0, grant_cnt1}, 64'd1);
`else
        chk("stats.cnt0_off", {48'd0, grant_cnt0}, 64'd0);
        chk("stats.cnt1_off", {48'd0, grant_cnt1}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
